// File: rtl/qdiv_iter.sv
// Iterative sign-magnitude Q-format divider: restoring division, one quotient bit per cycle.
// Define QDIV_ROUND_EN to compute a guard bit and round the magnitude half up.
module qdiv_iter #(
  parameter int N = 32,
  parameter int Q = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic         ovf,
  output logic         dbz
);

  localparam int RW = N + Q;
`ifdef QDIV_ROUND_EN
  localparam int K = N + Q;
`else
  localparam int K = N - 1 + Q;
`endif
  localparam int CW = $clog2(N + Q + 1);

  typedef enum logic [1:0] {IDLE, RUN, FMT, DONE} state_t;

  state_t        state_q;
  logic [K-1:0]  nq_q, nq_d;
  logic [RW-1:0] rem_q, rem_d, trial;
  logic [N-2:0]  dsr_q;
  logic [CW-1:0] cnt_q;
  logic          sign_q, zdiv_q;
  logic [N-1:0]  quot_q;
  logic          ovf_q, dbz_q, in_ready_q, out_valid_q;
  logic [RW-1:0] mag_raw;
  logic [N-2:0]  mag_fin;
  logic          satur;

  // nq_q shifts the numerator out at the top while quotient bits enter at the bottom.
  always_comb begin
    trial = {rem_q[RW-2:0], nq_q[K-1]};
    rem_d = trial;
    nq_d  = {nq_q[K-2:0], 1'b0};
    if (trial >= RW'(dsr_q)) begin
      rem_d    = trial - RW'(dsr_q);
      nq_d[0]  = 1'b1;
    end
  end

  always_comb begin
`ifdef QDIV_ROUND_EN
    mag_raw = RW'(nq_q[K-1:1]) + RW'(nq_q[0]);
`else
    mag_raw = RW'(nq_q);
`endif
    satur   = |mag_raw[RW-1:N-1];
    mag_fin = (satur || zdiv_q) ? {(N-1){1'b1}} : mag_raw[N-2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      nq_q        <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      zdiv_q      <= 1'b0;
      quot_q      <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q     <= dividend[N-1] ^ divisor[N-1];
            dsr_q      <= divisor[N-2:0];
            zdiv_q     <= (divisor[N-2:0] == '0);
            nq_q       <= K'(dividend[N-2:0]) << (K - (N - 1));
            rem_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        // A zero divisor spends this cycle idle and goes straight to formatting.
        RUN: begin
          if (zdiv_q) begin
            state_q <= FMT;
          end else begin
            rem_q <= rem_d;
            nq_q  <= nq_d;
            if (cnt_q == CW'(K - 1)) begin
              cnt_q   <= '0;
              state_q <= FMT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        FMT: begin
          quot_q      <= {sign_q & (|mag_fin), mag_fin};
          ovf_q       <= satur & ~zdiv_q;
          dbz_q       <= zdiv_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quot_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_qdiv_iter.sv
// Directed testbench for qdiv_iter (N=32, Q=15) with hand-computed quotients and latencies.
module tb_qdiv_iter;

  localparam int N = 32;
  localparam int Q = 15;
`ifdef QDIV_ROUND_EN
  localparam int LAT = N + Q + 1;
  localparam logic [N-1:0] THIRD = 32'h0000_2AAB;
`else
  localparam int LAT = N + Q;
  localparam logic [N-1:0] THIRD = 32'h0000_2AAA;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic         ovf;
  logic         dbz;

  int vectors = 0;
  int miscompares = 0;
  int lat;

  qdiv_iter #(.N(N), .Q(Q)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .ovf(ovf), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one accept edge, then scramble them and count edges to out_valid.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, output int edges);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
    end
  endtask

  task automatic checkResult(input string tag, input logic [N-1:0] expQ, input logic expOvf,
                             input logic expDbz, input int expLat, input int gotLat);
    checkOutput({tag, " latency"}, 64'(gotLat), 64'(expLat));
    checkOutput({tag, " quotient"}, 64'(quotient), 64'(expQ));
    checkOutput({tag, " ovf"}, 64'(ovf), 64'(expOvf));
    checkOutput({tag, " dbz"}, 64'(dbz), 64'(expDbz));
    checkOutput({tag, " in_ready"}, 64'(in_ready), 64'(0));
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, " idle in_ready"}, 64'(in_ready), 64'(1));
    checkOutput({tag, " idle out_valid"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    checkOutput("reset in_ready", 64'(in_ready), 64'(1));
    checkOutput("reset out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset quotient", 64'(quotient), 64'(0));
    checkOutput("reset flags", 64'({ovf, dbz}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(32'h0001_8000, 32'h0001_0000, lat);
    checkResult("3.0/2.0", 32'h0000_C000, 1'b0, 1'b0, LAT, lat);
    handshake("3.0/2.0");

    applyStimulus(32'h8001_8000, 32'h0001_0000, lat);
    checkResult("-3.0/2.0", 32'h8000_C000, 1'b0, 1'b0, LAT, lat);
    handshake("-3.0/2.0");

    applyStimulus(32'h0000_8000, 32'h0001_8000, lat);
    checkResult("1.0/3.0", THIRD, 1'b0, 1'b0, LAT, lat);
    handshake("1.0/3.0");

    applyStimulus(32'h0002_8000, 32'h8000_0000, lat);
    checkResult("5.0/-0", 32'hFFFF_FFFF, 1'b0, 1'b1, 2, lat);
    handshake("5.0/-0");

    applyStimulus(32'h7FFF_0000, 32'h0000_0001, lat);
    checkResult("overflow", 32'h7FFF_FFFF, 1'b1, 1'b0, LAT, lat);
    handshake("overflow");

    applyStimulus(32'h0000_0000, 32'h8000_8000, lat);
    checkResult("0/-1.0", 32'h0000_0000, 1'b0, 1'b0, LAT, lat);
    handshake("0/-1.0");

    // Stall in DONE with a competing request on the input side that must be ignored.
    applyStimulus(32'h0005_0000, 32'h8000_8000, lat);
    checkResult("10.0/-1.0", 32'h8005_0000, 1'b0, 1'b0, LAT, lat);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 32'h0000_8000;
    divisor  = 32'h0000_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold quotient", 64'(quotient), 64'(32'h8005_0000));
      checkOutput("hold flags", 64'({ovf, dbz}), 64'(0));
      checkOutput("hold in_ready", 64'(in_ready), 64'(0));
      checkOutput("hold out_valid", 64'(out_valid), 64'(1));
    end
    in_valid = 1'b0;
    handshake("hold");
    checkOutput("idle retains quotient", 64'(quotient), 64'(32'h8005_0000));

    applyStimulus(32'h0001_0000, 32'h0000_8000, lat);
    checkResult("back-to-back 2.0/1.0", 32'h0001_0000, 1'b0, 1'b0, LAT, lat);
    handshake("back-to-back");

    // Abort a division partway through RUN with an asynchronous reset.
    @(negedge clk);
    dividend = 32'h0000_8000;
    divisor  = 32'h0001_8000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort in_ready", 64'(in_ready), 64'(1));
    checkOutput("abort out_valid", 64'(out_valid), 64'(0));
    checkOutput("abort quotient", 64'(quotient), 64'(0));
    checkOutput("abort flags", 64'({ovf, dbz}), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort held out_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 5) begin
      @(negedge clk);
      checkOutput("abort no result", 64'(out_valid), 64'(0));
    end

    applyStimulus(32'h0001_8000, 32'h0001_0000, lat);
    checkResult("after abort 3.0/2.0", 32'h0000_C000, 1'b0, 1'b0, LAT, lat);
    handshake("after abort");

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
